sort_sequencer: RTL and testbench



---
 rtl/sort_sequencer.sv | 158 +++++++++++++++
 tb/tb_sort_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// Bubble-sort sequencer for the 16x8 data memory upstream: reads the element
// count word, sorts BASE..BASE+last in place, pulses done and reports swaps.
// Define SORT_DESC_EN for a descending sort (same timing).
module sort_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int BASE      = 0,
    parameter int LAST_ADDR = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [7:0]        swap_count
);

    // state     | meaning
    // IDLE      | waiting for start
    // LOAD_LAST | read index of final element, clamp, set up first pass
    // RD_A      | read element i
    // RD_B      | read element i+1, decide swap
    // WR_A      | write b to i
    // WR_B      | write a to i+1, count swap
    // NEXT      | advance index or close the pass
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_LAST, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_NEXT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] LP_SPAN = ADDR_W'(LAST_ADDR - BASE);

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_i, r_bound;
    logic [DATA_W-1:0]   r_a, r_b;
    logic                r_swapped;
    logic [7:0]          r_swap_count;

    logic [ADDR_W-1:0]   w_last_raw, w_last, w_i_inc;
    logic                w_more, w_swap, w_finish;

    assign w_last_raw = mem_rdata[ADDR_W-1:0];
    // An out-of-range count word would walk into the count word itself.
    assign w_last     = (w_last_raw >= LP_SPAN) ? (LP_SPAN - ADDR_W'(1)) : w_last_raw;
    assign w_i_inc    = r_i + ADDR_W'(1);
    assign w_more     = (w_i_inc < r_bound);
    assign w_finish   = !r_swapped || (r_bound == ADDR_W'(1));

`ifdef SORT_DESC_EN
    assign w_swap = (r_a < mem_rdata);
`else
    assign w_swap = (r_a > mem_rdata);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_LOAD_LAST;
            S_LOAD_LAST: w_next = (w_last == '0) ? S_DONE : S_RD_A;
            S_RD_A:      w_next = S_RD_B;
            S_RD_B:      w_next = w_swap ? S_WR_A : S_NEXT;
            S_WR_A:      w_next = S_WR_B;
            S_WR_B:      w_next = S_NEXT;
            S_NEXT:      w_next = (w_more || !w_finish) ? S_RD_A : S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i          <= '0;
            r_bound      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_swapped    <= 1'b0;
            r_swap_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) r_swap_count <= '0;
                S_LOAD_LAST: begin
                    r_bound   <= w_last;
                    r_i       <= '0;
                    r_swapped <= 1'b0;
                end
                S_RD_A: r_a <= mem_rdata;
                S_RD_B: r_b <= mem_rdata;
                S_WR_B: begin
                    r_swapped <= 1'b1;
                    if (r_swap_count != 8'hFF) r_swap_count <= r_swap_count + 8'd1;
                end
                S_NEXT: begin
                    if (w_more) begin
                        r_i <= w_i_inc;
                    end else if (!w_finish) begin
                        r_bound   <= r_bound - ADDR_W'(1);
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_LOAD_LAST: begin
                busy      = 1'b1;
                mem_raddr = LP_LAST;
            end
            S_RD_A: begin
                busy      = 1'b1;
                mem_raddr = LP_BASE + r_i;
            end
            S_RD_B: begin
                busy      = 1'b1;
                mem_raddr = LP_BASE + w_i_inc;
            end
            S_WR_A: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = LP_BASE + r_i;
                mem_wdata = r_b;
            end
            S_WR_B: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = LP_BASE + w_i_inc;
                mem_wdata = r_a;
            end
            S_NEXT:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign swap_count = r_swap_count;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: behavioural memory, scoreboard of expected
// results pushed at start and popped at each done pulse.
module tb_sort_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] mem_raddr, mem_waddr;
    logic [7:0] mem_rdata, mem_wdata;
    logic       mem_we, busy, done;
    logic [7:0] swap_count;

    sort_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt;

    int          exp_sc_q  [$];
    logic [71:0] exp_mem_q [$];
    int          exp_lat_q [$];

    localparam logic [63:0] D_SCRAMBLED = 64'h08_05_04_06_01_02_03_07; // 7,3,2,1,6,4,5,8
    localparam logic [63:0] D_SORTED    = 64'h08_07_06_05_04_03_02_01;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [63:0] data, input logic [7:0] lw);
        for (int k = 0; k < 8; k++) mem[k] = data[8*k +: 8];
        mem[8] = lw;
        for (int k = 9; k < 16; k++) mem[k] = 8'h5A;
    endtask

    // Reference result: inversion count and plain selection sort of 0..last.
    task automatic push_expect(input logic [63:0] data, input logic [7:0] lw, input int lat);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [71:0] em;
        int n, sc, sel;
        n = int'(lw[3:0]);
        if (n >= 8) n = 7;
        for (int k = 0; k < 8; k++) a[k] = data[8*k +: 8];
        sc = 0;
        for (int j = 0; j <= n; j++)
            for (int k = j + 1; k <= n; k++)
`ifdef SORT_DESC_EN
                if (a[j] < a[k]) sc++;
`else
                if (a[j] > a[k]) sc++;
`endif
        for (int j = 0; j <= n; j++) begin
            sel = j;
            for (int k = j + 1; k <= n; k++)
`ifdef SORT_DESC_EN
                if (a[k] > a[sel]) sel = k;
`else
                if (a[k] < a[sel]) sel = k;
`endif
            t = a[j]; a[j] = a[sel]; a[sel] = t;
        end
        for (int k = 0; k < 8; k++) em[8*k +: 8] = a[k];
        em[71:64] = lw;
        exp_sc_q.push_back(sc > 255 ? 255 : sc);
        exp_mem_q.push_back(em);
        exp_lat_q.push_back(lat);
    endtask

    // Called on a negedge with start just asserted; returns edges until done.
    task automatic wait_done(input bit hold, input bit poke, output int lat);
        lat = 0;
        we_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_we) we_cnt++;
            if (lat == 1) begin
                check_val("busy_after_accept", busy, 1);
                if (!hold) start = 1'b0;
            end
            if (poke && lat == 6) start = 1'b1;
            if (poke && lat == 7) start = 1'b0;
        end while (!done && lat < 2000);
        check_val("done_timeout", done, 1);
    endtask

    task automatic score(input int lat);
        int          esc, elat;
        logic [71:0] em;
        if (exp_sc_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
            return;
        end
        esc  = exp_sc_q.pop_front();
        em   = exp_mem_q.pop_front();
        elat = exp_lat_q.pop_front();
        check_val("swap_count", swap_count, esc);
        check_val("busy_at_done", busy, 0);
        for (int k = 0; k < 9; k++) check_val($sformatf("mem[%0d]", k), mem[k], em[8*k +: 8]);
        check_val("mem[9]", mem[9], 8'h5A);
        if (elat >= 0) check_val("done_latency", lat, elat);
    endtask

    task automatic run(input logic [63:0] data, input logic [7:0] lw, input int lat_exp,
                       input bit poke, input int we_exp);
        int lat;
        load_mem(data, lw);
        push_expect(data, lw, lat_exp);
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b0, poke, lat);
        score(lat);
        if (we_exp >= 0) check_val("write_count", we_cnt, we_exp);
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
    endtask

    initial begin
        int lat;
        logic [63:0] rd;
        reset = 1'b1;
        start = 1'b0;
        load_mem(D_SCRAMBLED, 8'd7);
        repeat (3) @(negedge clk);
        check_val("rst_we", mem_we, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_swap_count", swap_count, 0);
        check_val("rst_raddr", mem_raddr, 0);
        check_val("rst_waddr", mem_waddr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(negedge clk);

        run(D_SCRAMBLED, 8'd7, -1, 1'b0, -1);
        run(D_SORTED, 8'd7, 23, 1'b0, 0);
        run(D_SCRAMBLED, 8'd0, 2, 1'b0, 0);
        run(D_SCRAMBLED, 8'd15, -1, 1'b0, -1);
        run(D_SCRAMBLED, 8'd7, -1, 1'b1, -1);
        run(64'h03_03_09_01_09_02_05_04, 8'd7, -1, 1'b0, -1);
        for (int r = 0; r < 3; r++) begin
            rd = {$urandom, $urandom};
            run(rd, 8'($urandom_range(1, 7)), -1, 1'b0, -1);
        end

        // reset during the first WR_A
        load_mem(D_SCRAMBLED, 8'd7);
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!mem_we && lat < 100);
        check_val("reached_write", mem_we, 1);
        reset = 1'b1;
        #1;
        check_val("rst_mid_we", mem_we, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_swap_count", swap_count, 0);
        @(negedge clk);
        for (int k = 0; k < 8; k++)
            check_val($sformatf("no_partial_write[%0d]", k), mem[k], D_SCRAMBLED[8*k +: 8]);
        reset = 1'b0;
        @(negedge clk);
        run(D_SCRAMBLED, 8'd7, -1, 1'b0, -1);

        // start held high: re-trigger after DONE on already-sorted data
        load_mem(D_SCRAMBLED, 8'd7);
        push_expect(D_SCRAMBLED, 8'd7, -1);
        push_expect(D_SORTED, 8'd7, 23);
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b1, 1'b0, lat);
        score(lat);
        @(negedge clk);
        check_val("held_idle_done", done, 0);
        check_val("held_idle_busy", busy, 0);
        wait_done(1'b0, 1'b0, lat);
        score(lat);
        check_val("held_second_writes", we_cnt, 0);
        @(negedge clk);
        check_val("scoreboard_drained", exp_sc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
